// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum: XOR-accumulates framed WIDTH-bit words and emits checksum, parity, word count and overflow.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_last word stream;
//        out_valid/out_ready result handshake with out_xor, out_parity, out_count, out_ovf.
module xor_frame_checksum #(
  parameter int WIDTH = 8,
  parameter int MAX_LEN = 16,
  localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic ovf_r, ovf_nx, sat, accept;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == HOLD;
  assign accept    = in_valid && in_ready;
  assign sat       = cnt == CNT_W'(MAX_LEN);
  assign acc_nx    = acc ^ in_data;
  assign cnt_nx    = sat ? cnt : cnt + 1'b1;
  assign ovf_nx    = ovf_r | sat;
  always_comb begin
    state_nx = state;
    if (state == ACCUM) state_nx = (accept && in_last) ? HOLD : ACCUM;
    else state_nx = out_ready ? ACCUM : HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_r      <= 1'b0;
      out_xor    <= '0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
    end else if (accept && in_last) begin
      out_xor    <= acc_nx;
      out_parity <= ^acc_nx;
      out_count  <= cnt_nx;
      out_ovf    <= ovf_nx;
      acc        <= '0;
      cnt        <= '0;
      ovf_r      <= 1'b0;
    end else if (accept) begin
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf_r <= ovf_nx;
    end
  end
endmodule

// File: tb/tb_xor_frame_checksum.sv
// tb_xor_frame_checksum: directed-vector bench for xor_frame_checksum with MAX_LEN=4.
module tb_xor_frame_checksum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [7:0] out_xor;
  logic out_parity;
  logic [2:0] out_count;
  logic out_ovf;
  int n_cmp = 0;
  int n_bad = 0;

  xor_frame_checksum #(.WIDTH(8), .MAX_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_xor(out_xor), .out_parity(out_parity),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    int w;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_wait in_ready=%b required 1 within 20 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hAA;
    in_last = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({out_valid, out_xor, out_parity, out_count, out_ovf} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b x=%h p=%b c=%0d o=%b required all zero", out_valid, out_xor, out_parity, out_count, out_ovf);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_no_beat got v=%b r=%b required v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(8'hA5, 1'b0);
    beat(8'h3C, 1'b0);
    beat(8'hFF, 1'b1);
    n_cmp++;
    if ({out_valid, out_xor, out_parity, out_count, out_ovf, in_ready} !== {1'b1, 8'h66, 1'b0, 3'd3, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_result got v=%b x=%h p=%b c=%0d o=%b r=%b required v=1 x=66 p=0 c=3 o=0 r=0", out_valid, out_xor, out_parity, out_count, out_ovf, in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, in_ready, out_xor} !== {1'b0, 1'b1, 8'h66}) begin
      n_bad++;
      $display("FAIL basic_rearm got v=%b r=%b x=%h required v=0 r=1 x=66", out_valid, in_ready, out_xor);
    end
  endtask

  task automatic test_check_mode();
    beat(8'h12, 1'b0);
    beat(8'h34, 1'b0);
    beat(8'h26, 1'b1);
    n_cmp++;
    if ({out_valid, out_xor, out_parity, out_count, out_ovf} !== {1'b1, 8'h00, 1'b0, 3'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL check_mode got v=%b x=%h p=%b c=%0d o=%b required v=1 x=00 p=0 c=3 o=0", out_valid, out_xor, out_parity, out_count, out_ovf);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(8'h01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'hEE;
      in_last = 1'b1;
      n_cmp++;
      if ({out_valid, out_xor, out_parity, out_count, in_ready} !== {1'b1, 8'h01, 1'b1, 3'd1, 1'b0}) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d] got v=%b x=%h p=%b c=%0d r=%b required v=1 x=01 p=1 c=1 r=0", i, out_valid, out_xor, out_parity, out_count, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, in_ready, out_xor} !== {1'b0, 1'b1, 8'h01}) begin
      n_bad++;
      $display("FAIL backpressure_release got v=%b r=%b x=%h required v=0 r=1 x=01", out_valid, in_ready, out_xor);
    end
    beat(8'h02, 1'b1);
    n_cmp++;
    if ({out_xor, out_count} !== {8'h02, 3'd1}) begin
      n_bad++;
      $display("FAIL backpressure_no_leak got x=%h c=%0d required x=02 c=1", out_xor, out_count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) beat(8'(i), i == 6);
    n_cmp++;
    if ({out_valid, out_xor, out_parity, out_count, out_ovf} !== {1'b1, 8'h07, 1'b1, 3'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL overflow got v=%b x=%h p=%b c=%0d o=%b required v=1 x=07 p=1 c=4 o=1", out_valid, out_xor, out_parity, out_count, out_ovf);
    end
    beat(8'h80, 1'b1);
    n_cmp++;
    if ({out_valid, out_xor, out_parity, out_count, out_ovf} !== {1'b1, 8'h80, 1'b1, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL overflow_next got v=%b x=%h p=%b c=%0d o=%b required v=1 x=80 p=1 c=1 o=0", out_valid, out_xor, out_parity, out_count, out_ovf);
    end
    for (int i = 1; i <= 4; i++) beat(8'(i << 4), i == 4);
    n_cmp++;
    if ({out_xor, out_count, out_ovf} !== {8'h40, 3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL exact_max got x=%h c=%0d o=%b required x=40 c=4 o=0", out_xor, out_count, out_ovf);
    end
  endtask

  task automatic test_reset_mid();
    beat(8'hF0, 1'b0);
    beat(8'h0F, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, out_xor, out_count, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_state got v=%b x=%h c=%0d r=%b required v=0 x=00 c=0 r=1", out_valid, out_xor, out_count, in_ready);
    end
    beat(8'h55, 1'b1);
    n_cmp++;
    if ({out_valid, out_xor, out_parity, out_count, out_ovf} !== {1'b1, 8'h55, 1'b0, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_frame got v=%b x=%h p=%b c=%0d o=%b required v=1 x=55 p=0 c=1 o=0", out_valid, out_xor, out_parity, out_count, out_ovf);
    end
    tick();
    out_ready = 1'b0;
    beat(8'h33, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if ({out_valid, out_xor, out_count, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_hold got v=%b x=%h c=%0d r=%b required v=0 x=00 c=0 r=1", out_valid, out_xor, out_count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_check_mode();
    tick();
    test_backpressure();
    tick();
    test_overflow();
    tick();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
